// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the memory-access / writeback stage: writeback select and stage FSM state.
package mem_wb_stage_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_LUI = 2'd3
  } wbsel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DONE   = 2'd1,
    HALTED = 2'd2
  } memstate_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of EX/MEM inputs, data-cache handshake and MEM/WB outputs for mem_wb_stage.
interface mem_wb_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  import mem_wb_stage_pkg::*;

  logic          en;
  logic          dmemREN_in;
  logic          dmemWEN_in;
  logic [DW-1:0] dmemstore_in;
  logic [DW-1:0] portO_in;
  logic [DW-1:0] luiValue_in;
  logic [DW-1:0] pcp4_in;
  logic [RW-1:0] wsel_in;
  logic          RegWr_in;
  wbsel_t        MemToReg_in;
  logic          halt_in;
  logic          dhit;
  logic [DW-1:0] dmemload;
  logic          dmemREN;
  logic          dmemWEN;
  logic [DW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic          mem_stall;
  logic [DW-1:0] wb_wdat;
  logic [RW-1:0] wb_wsel;
  logic          wb_WEN;
  logic          wb_halt;

  modport stage (
    input  en, dmemREN_in, dmemWEN_in, dmemstore_in, portO_in, luiValue_in, pcp4_in,
           wsel_in, RegWr_in, MemToReg_in, halt_in, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
           wb_wdat, wb_wsel, wb_WEN, wb_halt
  );

  modport tb (
    output en, dmemREN_in, dmemWEN_in, dmemstore_in, portO_in, luiValue_in, pcp4_in,
           wsel_in, RegWr_in, MemToReg_in, halt_in, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
           wb_wdat, wb_wsel, wb_WEN, wb_halt
  );

endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage: holds a load/store to the data cache until dhit, stalls meanwhile,
// then selects writeback data into the MEM/WB register; halt freezes the stage until reset.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input logic            CLK,
  input logic            RST,
  mem_wb_stage_if.stage  bus
);

  memstate_t     r_state;
  logic [DW-1:0] r_load_buf;
  logic [DW-1:0] r_wb_wdat;
  logic [RW-1:0] r_wb_wsel;
  logic          r_wb_wen;
  logic          r_wb_halt;

  logic          w_idle;
  logic          w_mem_op;
  logic          w_wb_write;
  logic [DW-1:0] w_load_data;
  logic [DW-1:0] w_wdat;

  // Requests only leave the stage from IDLE, and drop the instant reset asserts.
  assign w_idle   = (r_state == IDLE) && !RST;
  assign w_mem_op = bus.dmemREN_in | bus.dmemWEN_in;

  assign bus.dmemWEN   = w_idle & bus.dmemWEN_in;
  assign bus.dmemREN   = w_idle & bus.dmemREN_in & ~bus.dmemWEN_in;
  assign bus.dmemaddr  = bus.portO_in;
  assign bus.dmemstore = bus.dmemstore_in;
  assign bus.mem_stall = w_idle & w_mem_op & ~bus.dhit;

  assign w_load_data = (r_state == DONE) ? r_load_buf : bus.dmemload;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_wb_write = 1'b0;
    unique case (r_state)
      IDLE:    w_wb_write = bus.en & ~(w_mem_op & ~bus.dhit);
      DONE:    w_wb_write = bus.en;
      default: w_wb_write = 1'b0;
    endcase
  end

  always_comb begin
    w_wdat = bus.portO_in;
    unique case (bus.MemToReg_in)
      WB_ALU: w_wdat = bus.portO_in;
      WB_MEM: w_wdat = w_load_data;
      WB_PC4: w_wdat = bus.pcp4_in;
      WB_LUI: w_wdat = bus.luiValue_in;
      default: w_wdat = bus.portO_in;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_load_buf <= '0;
      r_wb_wdat  <= '0;
      r_wb_wsel  <= '0;
      r_wb_wen   <= 1'b0;
      r_wb_halt  <= 1'b0;
    end else begin
      if (w_wb_write) begin
        r_wb_wdat <= w_wdat;
        r_wb_wsel <= bus.wsel_in;
        r_wb_wen  <= bus.RegWr_in & ~bus.halt_in;
        r_wb_halt <= bus.halt_in;
      end
      unique case (r_state)
        IDLE: begin
          if (w_mem_op && bus.dhit && !bus.en) begin
            r_load_buf <= bus.dmemload;
            r_state    <= DONE;
          end else if (w_wb_write && bus.halt_in) begin
            r_state <= HALTED;
          end
        end
        DONE: begin
          if (bus.en) r_state <= bus.halt_in ? HALTED : IDLE;
        end
        default: r_state <= HALTED;
      endcase
    end
  end

  assign bus.wb_wdat = r_wb_wdat;
  assign bus.wb_wsel = r_wb_wsel;
  assign bus.wb_WEN  = r_wb_wen;
  assign bus.wb_halt = r_wb_halt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized scoreboard bench for mem_wb_stage: driver pushes expected MEM/WB contents,
// monitor pops them whenever the stage advances (en & ~mem_stall).
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct {
    logic [DW-1:0] wdat;
    logic [RW-1:0] wsel;
    logic          wen;
    logic          halt;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.DW(DW), .RW(RW)) bus ();
  mem_wb_stage #(.DW(DW), .RW(RW)) dut (.CLK(clk), .RST(rst), .bus(bus));

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  stores_seen = 0;
  int  stores_exp = 0;
  bit  mdl_halted = 1'b0;
  wb_t mdl_frozen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts stores accepted by the cache and checks MEM/WB after each advance.
  initial begin
    bit  fire;
    wb_t e;
    forever begin
      @(negedge clk);
      fire = !rst && bus.en && !bus.mem_stall;
      if (!rst && bus.dmemWEN && bus.dhit) stores_seen++;
      @(posedge clk);
      #1;
      if (fire) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wb_wdat", bus.wb_wdat, e.wdat);
          check("wb_wsel", bus.wb_wsel, e.wsel);
          check("wb_WEN", bus.wb_WEN, e.wen);
          check("wb_halt", bus.wb_halt, e.halt);
        end
      end
    end
  end

  // One instruction through the stage; entered and left at posedge+1.
  // op: 0 none, 1 load, 2 store, 3 both (store wins). d: cycles before dhit. k: en=0 cycles after hit.
  task automatic run_txn(input int op, input logic [DW-1:0] addr, input logic [DW-1:0] sdat,
                         input logic [DW-1:0] lui, input logic [DW-1:0] pc4,
                         input logic [DW-1:0] hitval, input logic [RW-1:0] wsel,
                         input logic regwr, input wbsel_t sel, input logic halt,
                         input int d, input int k);
    bit  is_st   = (op >= 2);
    bit  is_ld   = (op == 1);
    bit  mem     = (op != 0) && !mdl_halted;
    bit  hit_done = 1'b0;
    bit  req_now;
    bit  committed = 1'b0;
    int  zeros = 0;
    int  cyc = 0;
    wb_t e;

    if (mdl_halted) begin
      e = mdl_frozen;
    end else begin
      case (sel)
        WB_ALU: e.wdat = addr;
        WB_MEM: e.wdat = hitval;
        WB_PC4: e.wdat = pc4;
        default: e.wdat = lui;
      endcase
      e.wsel = wsel;
      e.wen  = regwr && !halt;
      e.halt = halt;
      if (halt) begin
        mdl_halted = 1'b1;
        mdl_frozen = e;
      end
    end
    exp_q.push_back(e);
    if (mem && is_st) stores_exp++;

    bus.dmemREN_in   = (op == 1) || (op == 3);
    bus.dmemWEN_in   = is_st;
    bus.dmemstore_in = sdat;
    bus.portO_in     = addr;
    bus.luiValue_in  = lui;
    bus.pcp4_in      = pc4;
    bus.wsel_in      = wsel;
    bus.RegWr_in     = regwr;
    bus.MemToReg_in  = sel;
    bus.halt_in      = halt;

    while (!committed && cyc < 40) begin
      req_now = mem && !hit_done;
      if (req_now) begin
        bus.dhit     = (cyc == d);
        bus.dmemload = hitval;
        if (cyc == d) begin
          bus.en   = (k == 0);
          zeros    = (k == 0) ? 0 : 1;
          hit_done = 1'b1;
        end else begin
          bus.en = 1'($urandom_range(0, 1));
        end
      end else if (mem) begin
        bus.dhit     = 1'($urandom_range(0, 1));
        bus.dmemload = $urandom;
        bus.en       = (zeros >= k);
        if (zeros < k) zeros++;
      end else begin
        bus.dhit     = 1'($urandom_range(0, 1));
        bus.dmemload = hitval;
        bus.en       = ($urandom_range(0, 3) != 0);
      end

      @(negedge clk);
      check("dmemREN", bus.dmemREN, req_now && is_ld);
      check("dmemWEN", bus.dmemWEN, req_now && is_st);
      check("mem_stall", bus.mem_stall, req_now && !bus.dhit);
      if (req_now) begin
        check("dmemaddr", bus.dmemaddr, addr);
        if (is_st) check("dmemstore", bus.dmemstore, sdat);
      end
      committed = bus.en && (!mem || hit_done);
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!committed) check("txn_timeout", 0, 1);
  endtask

  initial begin
    logic [1:0] s;
    rst              = 1'b1;
    bus.en           = 1'b1;
    bus.dmemREN_in   = 1'b1;
    bus.dmemWEN_in   = 1'b1;
    bus.dmemstore_in = '0;
    bus.portO_in     = 32'h100;
    bus.luiValue_in  = '0;
    bus.pcp4_in      = '0;
    bus.wsel_in      = '0;
    bus.RegWr_in     = 1'b0;
    bus.MemToReg_in  = WB_ALU;
    bus.halt_in      = 1'b0;
    bus.dhit         = 1'b0;
    bus.dmemload     = '0;

    #12;
    check("rst_dmemREN", bus.dmemREN, 0);
    check("rst_dmemWEN", bus.dmemWEN, 0);
    check("rst_mem_stall", bus.mem_stall, 0);
    check("rst_wb_wdat", bus.wb_wdat, 0);
    check("rst_wb_wsel", bus.wb_wsel, 0);
    check("rst_wb_WEN", bus.wb_WEN, 0);
    check("rst_wb_halt", bus.wb_halt, 0);
    bus.en         = 1'b0;
    bus.dmemREN_in = 1'b0;
    bus.dmemWEN_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    run_txn(1, 32'h100, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 5'd5, 1'b1, WB_MEM, 1'b0, 0, 0);
    run_txn(1, 32'h100, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 5'd6, 1'b1, WB_MEM, 1'b0, 3, 0);
    run_txn(2, 32'h200, 32'h55AA, 32'h0, 32'h0, 32'h0, 5'd7, 1'b0, WB_ALU, 1'b0, 0, 2);
    run_txn(1, 32'h300, 32'h0, 32'h0, 32'h0, 32'h600DF00D, 5'd8, 1'b1, WB_MEM, 1'b0, 1, 2);
    run_txn(0, 32'h0, 32'h0, 32'h0, 32'h44, 32'h0, 5'd1, 1'b1, WB_PC4, 1'b0, 0, 0);
    run_txn(0, 32'h0, 32'h0, 32'h12340000, 32'h0, 32'h0, 5'd2, 1'b1, WB_LUI, 1'b0, 0, 0);
    run_txn(0, 32'h7, 32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, WB_ALU, 1'b0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      s = 2'($urandom_range(0, 3));
      run_txn($urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom, $urandom,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), wbsel_t'(s), 1'b0,
              $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Halt, then further instructions must leave MEM/WB frozen and issue no requests.
    run_txn(0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, WB_ALU, 1'b1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      s = 2'($urandom_range(0, 3));
      run_txn($urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom, $urandom,
              5'($urandom_range(0, 31)), 1'b1, wbsel_t'(s), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset in the middle of a pending load.
    bus.en         = 1'b0;
    bus.dhit       = 1'b0;
    bus.dmemREN_in = 1'b1;
    bus.dmemWEN_in = 1'b0;
    bus.portO_in   = 32'h100;
    bus.halt_in    = 1'b0;
    rst            = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_halted = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pend_dmemREN", bus.dmemREN, 1);
    check("pend_mem_stall", bus.mem_stall, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_dmemREN", bus.dmemREN, 0);
    check("midrst_mem_stall", bus.mem_stall, 0);
    check("midrst_wb_wdat", bus.wb_wdat, 0);
    check("midrst_wb_wsel", bus.wb_wsel, 0);
    check("midrst_wb_WEN", bus.wb_WEN, 0);
    check("midrst_wb_halt", bus.wb_halt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_txn(1, 32'h180, 32'h0, 32'h0, 32'h0, 32'h0BADF00D, 5'd11, 1'b1, WB_MEM, 1'b0, 1, 1);
    run_txn(2, 32'h184, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1, WB_ALU, 1'b0, 2, 1);

    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("store_count", stores_seen, stores_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
